// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the funct3 width codes and the owner encoding of the response slot.
package mem_arb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority. A starvation counter forces a fetch grant after STARVE_MAX consecutive denials.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_funct3,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_wins;

  // Grants are combinational so the memory sees the winner in the same cycle.
  always_comb begin
    fetch_wins = if_req & (~d_req | (starve_q == STARVE_LIM));
    if_gnt     = ~rst & fetch_wins;
    d_gnt      = ~rst & d_req & ~fetch_wins;

    m_read   = 1'b0;
    m_write  = 1'b0;
    m_funct3 = 3'b000;
    m_addr   = '0;
    m_wdata  = '0;
    if (if_gnt) begin
      m_read   = 1'b1;
      m_funct3 = F3_W;
      m_addr   = if_addr;
    end else if (d_gnt) begin
      m_read   = ~d_we;
      m_write  = d_we;
      m_funct3 = d_funct3;
      m_addr   = d_addr;
      m_wdata  = d_wdata;
    end
  end

  always_comb begin
    owner_d    = NONE;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_gnt) begin
      owner_d    = FETCH;
      if_rdata_d = m_rdata;
    end else if (d_gnt) begin
      owner_d   = d_we ? STORE : LOAD;
      d_rdata_d = d_we ? '0 : m_rdata;
    end

    starve_d = '0;
    if (if_req & ~if_gnt)
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= NONE;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = (owner_q == FETCH);
  assign d_valid  = (owner_q == LOAD) || (owner_q == STORE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port, byte-addressed unified `Memory` (256 bytes, funct3-encoded loads/stores) between the instruction-fetch stage and the data-memory stage. Exactly one access is issued per cycle. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. Sits between the core's IF/MEM stages and the `Memory` instance; both requesters see a registered, fixed one-cycle read response.

## Interface
- `ADDR_W`, 8, memory byte-address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 3, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch byte address
- `if_gnt`  out  1  fetch granted this cycle
- `if_rdata`  out  DATA_W  fetched word (registered)
- `if_valid`  out  1  `if_rdata` valid (one-cycle pulse)
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_funct3`  in  3  load/store width code
- `d_addr`  in  ADDR_W  data byte address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data granted this cycle
- `d_rdata`  out  DATA_W  load result (registered); 0 for stores
- `d_valid`  out  1  load data or store-complete (one-cycle pulse)
- `m_read`, `m_write`  out  1 each  to `Memory` MemRead/MemWrite
- `m_funct3`  out  3  to `Memory` funct3
- `m_addr`  out  ADDR_W  to `Memory` addr
- `m_wdata`  out  DATA_W  to `Memory` data_in
- `m_rdata`  in  DATA_W  from `Memory` data_out (combinational)

## Operation
- Grant is combinational from the requests and `starve_cnt`:
  - only one request: that requester wins.
  - both requesting: data wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
  - `if_gnt` and `d_gnt` are never both high.
  - both grants are forced to 0 while `rst` is high.
- Memory drive, same cycle as the grant:
  - fetch: `m_read=1`, `m_write=0`, `m_funct3=3'b010`, `m_addr=if_addr`.
  - data: `m_read=~d_we`, `m_write=d_we`, `m_funct3=d_funct3`, `m_addr=d_addr`, `m_wdata=d_wdata`.
  - no grant: `m_read=0`, `m_write=0`, all other memory outputs 0.
- Owner register `owner` ∈ {NONE, FETCH, LOAD, STORE} is latched at each edge from the grant. It selects the response on the following cycle.
- At the granting edge, `m_rdata` is captured into the responding requester's rdata register. The store commits inside `Memory` at the same edge.
- `starve_cnt`:
  - increments (saturating at `STARVE_MAX`) on each edge where `if_req & ~if_gnt`.
  - clears on an edge where `if_gnt` is high or `if_req` is low.
- Requesters hold `req`, address, funct3 and wdata stable until they see `gnt`. The arbiter does not buffer requests.
- Addresses and funct3 pass through unmodified. Misalignment and `addr+n` wrap past 255 are `Memory` behaviour.

## Timing
- Reset values: `if_gnt=d_gnt=0`, `if_valid=d_valid=0`, `if_rdata=d_rdata=0`, `owner=NONE`, `starve_cnt=0`, `m_read=m_write=0`.
- Latency: grant in cycle N; valid and data in cycle N+1; a new grant is possible in cycle N+1, giving throughput of 1 access per cycle.
- `d_valid` pulses for stores too, with `d_rdata=0`. Data registers not being updated hold their previous values.
- Reset asserted mid-access: the pending valid is dropped, i.e. the valid in the cycle after `rst` reads 0. No write commits in any cycle where `rst` is high.
- Simultaneous requests on every cycle give the pattern D,D,D,F repeating for `STARVE_MAX=3`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - funct3 constants `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - owner enum `owner_t`.
- No sub-module. The arbiter is a single FSM plus counter; `Memory` is instantiated alongside it by the parent.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0`, with mem[3:0]=0xFFB00093 → `if_gnt=1` same cycle; next cycle `if_valid=1`, `if_rdata=0xFFB00093`.
- Store then load: SW 0x12345678 @ 0x40, then LB @ 0x43 → `d_valid` on both; `d_rdata=0` for the store, then 0x00000012.
- Signed/unsigned loads: mem[0x48]=0x82. LB gives `0xFFFFFF82`; LBU gives `0x00000082`.
- Contention: `if_req` and `d_req` held high for 8 cycles, `STARVE_MAX=3` → grants D,D,D,F,D,D,D,F. `m_write` is never high on a fetch cycle.
- Reset mid-access: `rst` asserted in the cycle a store SW 0xAAAA5555 @ 0x50 is requested → no commit, so mem[0x50..0x53] is unchanged; all outputs 0 the next cycle.
- Idle: no requests → `m_read=m_write=0`, no valids, `starve_cnt` stays 0.
